// File: rtl/phase_sequencer.sv
// phase_sequencer
//
// Three-phase timing sequencer. An accepted start walks the block through
// P1 -> P2 -> P3, each phase lasting its programmed number of ticks, where a
// tick is TICK_DIV clock cycles. After P3 it either loops back to P1
// (loop_en=1) or returns to IDLE with a one-cycle done pulse. hold freezes
// the phase timing. abort forces an immediate return to IDLE.
//
// Parameters
//   TICK_DIV   clock cycles per duration tick (2..255)
//   DUR_W      width of each phase-duration register
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   cfg_we     duration-register write strobe (honoured only in IDLE)
//   cfg_addr   phase select for writes: 1=P1, 2=P2, 3=P3, 0 unmapped
//   cfg_data   duration write data in ticks (0 is stored as 1)
//   start_req  level request to begin a sequence
//   start_ack  one-cycle pulse when a start is accepted
//   abort      force return to IDLE
//   hold       freeze phase timing while high
//   loop_en    continuous loop (1) or single pass (0), sampled at P3 end
//   phase      current state: 0=IDLE, 1=P1, 2=P2, 3=P3
//   busy       high whenever phase != IDLE
//   done       one-cycle pulse on normal completion of a single pass
//   cycle_cnt  completed P3 phases since the last accepted start (saturates)

module phase_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int DUR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [DUR_W-1:0] cfg_data,
    input  logic             start_req,
    output logic             start_ack,
    input  logic             abort,
    input  logic             hold,
    input  logic             loop_en,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done,
    output logic [7:0]       cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        P3   = 2'd3
    } state_t;

    localparam logic [7:0]       PRESC_LAST = 8'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] DUR1_RST   = DUR_W'(2);
    localparam logic [DUR_W-1:0] DUR2_RST   = DUR_W'(4);
    localparam logic [DUR_W-1:0] DUR3_RST   = DUR_W'(6);
    localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);

    state_t           state;
    logic [7:0]       prescaler;
    logic [DUR_W-1:0] tick_cnt;
    logic [DUR_W-1:0] dur1;
    logic [DUR_W-1:0] dur2;
    logic [DUR_W-1:0] dur3;
    logic [DUR_W-1:0] cur_dur;
    logic [DUR_W-1:0] wr_data;
    logic             tick;
    logic             phase_end;

    // phase is the state register itself, so it is registered as-is.
    assign phase = state;

    // Duration of the phase currently running; a zero write is promoted to
    // one tick so that every phase always makes forward progress.
    always_comb begin
        cur_dur = dur3;
        case (state)
            P1:      cur_dur = dur1;
            P2:      cur_dur = dur2;
            default: cur_dur = dur3;
        endcase
        wr_data = (cfg_data == '0) ? DUR_ONE : cfg_data;
    end

    assign tick      = (prescaler == PRESC_LAST);
    assign phase_end = tick && (tick_cnt == cur_dur - DUR_ONE);

    // Sequencer FSM with prescaler, tick counter, duration registers and all
    // outputs. abort is checked before hold and phase completion so it wins
    // every same-cycle conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            start_ack <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= 8'd0;
            prescaler <= 8'd0;
            tick_cnt  <= '0;
            dur1      <= DUR1_RST;
            dur2      <= DUR2_RST;
            dur3      <= DUR3_RST;
        end else begin
            start_ack <= 1'b0;
            done      <= 1'b0;
            if (state == IDLE) begin
                if (cfg_we) begin
                    case (cfg_addr)
                        2'd1:    dur1 <= wr_data;
                        2'd2:    dur2 <= wr_data;
                        2'd3:    dur3 <= wr_data;
                        default: ;
                    endcase
                end
                if (start_req && !abort) begin
                    state     <= P1;
                    busy      <= 1'b1;
                    start_ack <= 1'b1;
                    cycle_cnt <= 8'd0;
                    prescaler <= 8'd0;
                    tick_cnt  <= '0;
                end
            end else if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                prescaler <= 8'd0;
                tick_cnt  <= '0;
            end else if (!hold) begin
                if (tick) begin
                    prescaler <= 8'd0;
                    if (phase_end) begin
                        tick_cnt <= '0;
                        case (state)
                            P1: state <= P2;
                            P2: state <= P3;
                            default: begin
                                if (cycle_cnt != 8'hFF) begin
                                    cycle_cnt <= cycle_cnt + 8'd1;
                                end
                                if (loop_en) begin
                                    state <= P1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        tick_cnt <= tick_cnt + DUR_ONE;
                    end
                end else begin
                    prescaler <= prescaler + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
//
// Self-checking bench for phase_sequencer. A cycle-level reference model
// tracks the phase as "cycles elapsed in this phase" against
// duration*TICK_DIV and is compared with every DUT output on each falling
// edge. Directed scenarios add hand-computed phase lengths and counter
// values on top of the model comparison.

module tb_phase_sequencer;

    localparam int TICK_DIV = 4;
    localparam int DUR_W    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_addr = 2'd0;
    logic [DUR_W-1:0] cfg_data = '0;
    logic             start_req = 1'b0;
    logic             start_ack;
    logic             abort = 1'b0;
    logic             hold = 1'b0;
    logic             loop_en = 1'b0;
    logic [1:0]       phase;
    logic             busy;
    logic             done;
    logic [7:0]       cycle_cnt;

    always #5 clk = ~clk;

    phase_sequencer #(
        .TICK_DIV(TICK_DIV),
        .DUR_W   (DUR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start_req(start_req),
        .start_ack(start_ack),
        .abort    (abort),
        .hold     (hold),
        .loop_en  (loop_en),
        .phase    (phase),
        .busy     (busy),
        .done     (done),
        .cycle_cnt(cycle_cnt)
    );

    // Reference model: phase number, cycles spent in the current phase, and
    // the programmed durations; a phase ends once its full dur*TICK_DIV
    // cycles of un-held time have elapsed.
    int m_phase;
    int m_elapsed;
    int m_cnt;
    int m_ack;
    int m_done;
    int m_dur [4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_cnt     = 0;
            m_ack     = 0;
            m_done    = 0;
            m_dur[0]  = 0;
            m_dur[1]  = 2;
            m_dur[2]  = 4;
            m_dur[3]  = 6;
        end else begin
            m_ack  = 0;
            m_done = 0;
            if (m_phase == 0) begin
                if (cfg_we && cfg_addr != 2'd0)
                    m_dur[cfg_addr] = (cfg_data == 0) ? 1 : int'(cfg_data);
                if (start_req && !abort) begin
                    m_ack     = 1;
                    m_phase   = 1;
                    m_elapsed = 0;
                    m_cnt     = 0;
                end
            end else if (abort) begin
                m_phase   = 0;
                m_elapsed = 0;
            end else if (!hold) begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == m_dur[m_phase] * TICK_DIV) begin
                    m_elapsed = 0;
                    if (m_phase < 3) begin
                        m_phase = m_phase + 1;
                    end else begin
                        if (m_cnt < 255) m_cnt = m_cnt + 1;
                        if (loop_en) begin
                            m_phase = 1;
                        end else begin
                            m_phase = 0;
                            m_done  = 1;
                        end
                    end
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int ack_total  = 0;
    int done_total = 0;
    int last_len [4];
    int run_len = 0;
    int prev_ph = 0;
    int a0;
    int d0;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance to the falling edge, update phase-length and pulse
    // bookkeeping, and compare every output against the model.
    task automatic step();
        @(negedge clk);
        if (int'(phase) == prev_ph) begin
            run_len++;
        end else begin
            last_len[prev_ph] = run_len;
            run_len = 1;
            prev_ph = int'(phase);
        end
        ack_total  += int'(start_ack);
        done_total += int'(done);
        checkOutput("model phase",     int'(phase),     m_phase);
        checkOutput("model busy",      int'(busy),      (m_phase != 0) ? 1 : 0);
        checkOutput("model start_ack", int'(start_ack), m_ack);
        checkOutput("model done",      int'(done),      m_done);
        checkOutput("model cycle_cnt", int'(cycle_cnt), m_cnt);
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic h, input logic l);
        start_req = s;
        abort     = a;
        hold      = h;
        loop_en   = l;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [DUR_W-1:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = '0;
    endtask

    task automatic startSeq();
        for (int i = 0; i < 4; i++) last_len[i] = 0;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int max_cycles);
        int found;
        found = 0;
        for (int i = 0; i < max_cycles && found == 0; i++) begin
            step();
            if (phase == 2'd0) found = 1;
        end
        checkOutput({name, " reaches IDLE"}, found, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) last_len[i] = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset values
        runCycles(2);
        checkOutput("reset phase",     int'(phase),     0);
        checkOutput("reset busy",      int'(busy),      0);
        checkOutput("reset cycle_cnt", int'(cycle_cnt), 0);
        checkOutput("reset done",      int'(done),      0);

        // Default single pass, start on the first edge after reset release
        reset = 1'b0;
        a0 = ack_total;
        d0 = done_total;
        startSeq();
        checkOutput("T1 start_ack", int'(start_ack), 1);
        waitIdle("T1", 80);
        checkOutput("T1 done with idle", int'(done), 1);
        checkOutput("T1 P1 length", last_len[1], 8);
        checkOutput("T1 P2 length", last_len[2], 16);
        checkOutput("T1 P3 length", last_len[3], 24);
        checkOutput("T1 cycle_cnt", int'(cycle_cnt), 1);
        checkOutput("T1 ack pulses", ack_total - a0, 1);
        checkOutput("T1 done pulses", done_total - d0, 1);

        // Duration writes, including zero promoted to one tick
        cfgWrite(2'd2, 4'd1);
        startSeq();
        waitIdle("T2a", 80);
        checkOutput("T2 P1 length", last_len[1], 8);
        checkOutput("T2 P2 dur=1 length", last_len[2], 4);
        cfgWrite(2'd1, 4'd0);
        startSeq();
        waitIdle("T2b", 80);
        checkOutput("T2 P1 dur=0 length", last_len[1], 4);
        cfgWrite(2'd1, 4'd2);
        cfgWrite(2'd2, 4'd4);

        // Continuous loop for three passes, then single-pass exit
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        d0 = done_total;
        startSeq();
        for (int k = 1; k <= 3; k++) begin
            runCycles(48);
            checkOutput("T3 loop cycle_cnt", int'(cycle_cnt), k);
            checkOutput("T3 loop back in P1", int'(phase), 1);
        end
        checkOutput("T3 no done while looping", done_total - d0, 0);
        loop_en = 1'b0;
        waitIdle("T3", 60);
        checkOutput("T3 final cycle_cnt", int'(cycle_cnt), 4);
        checkOutput("T3 done after exit", done_total - d0, 1);

        // Hold for 10 cycles mid-P2 with an ignored config write
        startSeq();
        runCycles(12);
        hold = 1'b1;
        cfgWrite(2'd3, 4'd1);
        runCycles(9);
        hold = 1'b0;
        waitIdle("T4", 80);
        checkOutput("T4 P1 length", last_len[1], 8);
        checkOutput("T4 held P2 length", last_len[2], 26);
        checkOutput("T4 P3 unchanged", last_len[3], 24);

        // Abort in P3 of the second looped pass
        loop_en = 1'b1;
        d0 = done_total;
        startSeq();
        runCycles(78);
        checkOutput("T5 in P3 before abort", int'(phase), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        loop_en = 1'b0;
        checkOutput("T5 abort to IDLE", int'(phase), 0);
        checkOutput("T5 abort cycle_cnt held", int'(cycle_cnt), 1);
        checkOutput("T5 no done on abort", done_total - d0, 0);

        // Abort together with start_req in IDLE
        a0 = ack_total;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("T5 abort+start stays IDLE", int'(phase), 0);
        checkOutput("T5 abort+start no ack", ack_total - a0, 0);
        checkOutput("T5 abort+start cycle_cnt", int'(cycle_cnt), 1);

        // Asynchronous reset mid-P1 restores outputs and durations
        cfgWrite(2'd1, 4'd3);
        startSeq();
        runCycles(3);
        #2 reset = 1'b1;
        #1;
        checkOutput("T6 async phase",     int'(phase),     0);
        checkOutput("T6 async busy",      int'(busy),      0);
        checkOutput("T6 async start_ack", int'(start_ack), 0);
        checkOutput("T6 async done",      int'(done),      0);
        checkOutput("T6 async cycle_cnt", int'(cycle_cnt), 0);
        step();
        reset = 1'b0;
        startSeq();
        waitIdle("T6", 80);
        checkOutput("T6 P1 restored", last_len[1], 8);
        checkOutput("T6 P2 restored", last_len[2], 16);
        checkOutput("T6 P3 restored", last_len[3], 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
